// File: rtl/tap_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tap_seq_pkg
// Purpose  : Shared types and default constants for the tap-down sequencer.
//            Holds the two-state FSM encoding and the default counter
//            width / start value (63 taps, indices 62..0).
// Revision : 1.0 - initial release
// ============================================================================
package tap_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tap_state_e;

    localparam int TAP_WIDTH = 6;
    localparam int TAP_TOP   = 62;

endpackage : tap_seq_pkg
`default_nettype wire

// File: rtl/tap_down_count.sv
`default_nettype none
// ============================================================================
// Module   : tap_down_count
// Purpose  : Tap index register with synchronous load, reload-to-top and
//            saturating decrement, plus the ripple-borrow output used to
//            cascade stages.
// Ports    : clk       - rising-edge clock
//            clr_n     - synchronous active-low clear (Q <= 0)
//            ld        - parallel load of d (highest priority after clear)
//            load_top  - reload the start value TOP
//            dec       - decrement by one (ignored when q is zero)
//            ent       - trickle enable, gates the borrow output
//            d         - parallel load value
//            q         - current tap index (registered)
//            rbo       - ripple-borrow out: ent AND (q == 0), combinational
// Revision : 1.0 - initial release
// ============================================================================
module tap_down_count
    import tap_seq_pkg::*;
#(
    parameter int WIDTH = TAP_WIDTH,
    parameter int TOP   = TAP_TOP
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ld,
    input  logic             load_top,
    input  logic             dec,
    input  logic             ent,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rbo
);

    localparam logic [WIDTH-1:0] C_TOP = WIDTH'(TOP);

    logic [WIDTH-1:0] r_q;
    logic             w_q_zero;

    assign w_q_zero = (r_q == '0);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (load_top) begin
            r_q <= C_TOP;
        end else if (dec && !w_q_zero) begin
            // Zero is a terminal condition handled by the FSM; never wrap.
            r_q <= r_q - 1'b1;
        end
    end

    assign q   = r_q;
    assign rbo = ent & w_q_zero;

endmodule : tap_down_count
`default_nettype wire

// File: rtl/tap_down_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tap_down_sequencer
// Purpose  : Walks a tap index from TOP down to 0 once per START, with
//            parallel/trickle count enables, parallel load, a BUSY flag and
//            a one-cycle DONE pulse on the terminal edge.
// Ports    : CLK    - rising-edge clock
//            CLR_N  - synchronous active-low reset
//            START  - begin a pass (sampled only in IDLE)
//            LD     - parallel load of D into Q (any state)
//            ENP    - parallel count enable
//            ENT    - trickle count enable, also gates RBO
//            D      - load value
//            Q      - current tap index (registered)
//            RBO    - ripple-borrow out, ENT AND (Q == 0)
//            BUSY   - high while in RUN (registered)
//            DONE   - one-cycle pulse after the terminal edge (registered)
// Config   : TAP_SEQ_AUTO_RESTART_EN - when defined, the terminal edge
//            reloads TOP and stays in RUN for continuous passes; otherwise
//            the sequencer returns to IDLE with Q held at 0.
// Revision : 1.0 - initial release
// ============================================================================
module tap_down_sequencer
    import tap_seq_pkg::*;
#(
    parameter int WIDTH = TAP_WIDTH,
    parameter int TOP   = TAP_TOP
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             START,
    input  logic             LD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RBO,
    output logic             BUSY,
    output logic             DONE
);

    tap_state_e r_state;
    tap_state_e w_state_next;
    logic       r_done;
    logic       w_count_en;
    logic       w_q_zero;
    logic       w_terminal;
    logic       w_load_top;
    logic       w_dec;

    assign w_count_en = ENP & ENT;
    assign w_q_zero   = (Q == '0);
    // LD outranks the terminal edge, so a load there cancels DONE.
    assign w_terminal = (r_state == RUN) & w_count_en & w_q_zero & ~LD;

    always_comb begin
        w_state_next = r_state;
        w_load_top   = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            IDLE: begin
                if (START && !LD) begin
                    w_state_next = RUN;
                    w_load_top   = 1'b1;
                end
            end
            RUN: begin
                if (!LD && w_count_en) begin
                    if (w_q_zero) begin
`ifdef TAP_SEQ_AUTO_RESTART_EN
                        w_load_top   = 1'b1;
`else
                        w_state_next = IDLE;
`endif
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_terminal;
        end
    end

    assign BUSY = (r_state == RUN);
    assign DONE = r_done;

    tap_down_count #(
        .WIDTH (WIDTH),
        .TOP   (TOP)
    ) u_count (
        .clk      (CLK),
        .clr_n    (CLR_N),
        .ld       (LD),
        .load_top (w_load_top),
        .dec      (w_dec),
        .ent      (ENT),
        .d        (D),
        .q        (Q),
        .rbo      (RBO)
    );

endmodule : tap_down_sequencer
`default_nettype wire

// File: tb/tb_tap_down_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_down_sequencer
// Purpose  : Directed scoreboard bench for tap_down_sequencer. The driver
//            pushes hand-computed expectations tagged with the edge they
//            apply to; a monitor pops and compares after each rising edge,
//            and separately matches every DONE pulse to an expected edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_down_sequencer;

    logic       CLK = 1'b0;
    logic       CLR_N;
    logic       START;
    logic       LD;
    logic       ENP;
    logic       ENT;
    logic [5:0] D;
    logic [5:0] Q;
    logic       RBO;
    logic       BUSY;
    logic       DONE;

    always #5 CLK = ~CLK;

    tap_down_sequencer #(
        .WIDTH (6),
        .TOP   (62)
    ) dut (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .START (START),
        .LD    (LD),
        .ENP   (ENP),
        .ENT   (ENT),
        .D     (D),
        .Q     (Q),
        .RBO   (RBO),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    typedef struct {
        string      name;
        int         edge_n;
        logic [5:0] q;
        logic       busy;
        logic       done;
        logic       chk_rbo;
        logic       rbo;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   mon_edge = 0;
    int   drv_edge = 0;

    // Expectation for the state right after the next rising edge.
    task automatic step(input string name, input logic [5:0] q, input logic busy,
                        input logic done, input logic chk_rbo, input logic rbo);
        exp_t e;
        e.name    = name;
        e.edge_n  = drv_edge + 1;
        e.q       = q;
        e.busy    = busy;
        e.done    = done;
        e.chk_rbo = chk_rbo;
        e.rbo     = rbo;
        exp_q.push_back(e);
        if (done) done_q.push_back(drv_edge + 1);
        @(negedge CLK);
        drv_edge++;
    endtask

    // Monitor: compares after each rising edge, decoupled from the driver.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            mon_edge++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].edge_n == mon_edge) begin
                e = exp_q.pop_front();
                checks++;
                if (Q !== e.q || BUSY !== e.busy || DONE !== e.done ||
                    (e.chk_rbo && RBO !== e.rbo)) begin
                    errors++;
                    $display("FAIL %s edge %0d: got Q=%0d BUSY=%b DONE=%b RBO=%b, expected Q=%0d BUSY=%b DONE=%b RBO=%b",
                             e.name, mon_edge, Q, BUSY, DONE, RBO,
                             e.q, e.busy, e.done, e.chk_rbo ? e.rbo : RBO);
                end
            end
            while (done_q.size() > 0 && done_q[0] < mon_edge) void'(done_q.pop_front());
            if (DONE === 1'b1) begin
                checks++;
                if (done_q.size() == 0 || done_q[0] != mon_edge) begin
                    errors++;
                    $display("FAIL done_pulse edge %0d: got DONE=1, expected DONE=0", mon_edge);
                end else begin
                    void'(done_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit at edge %0d", mon_edge);
        $fatal(1);
    end

    initial begin
        // Reset with every other input asserted.
        CLR_N = 1'b0; START = 1'b1; LD = 1'b1; D = 6'd9; ENP = 1'b1; ENT = 1'b1;
        step("reset_1", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("reset_2", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        CLR_N = 1'b1; LD = 1'b0; D = 6'd0;

`ifdef TAP_SEQ_AUTO_RESTART_EN
        step("auto_start", 6'd62, 1'b1, 1'b0, 1'b1, 1'b0);
        START = 1'b0;
        for (int k = 61; k >= 0; k--)
            step("auto_cnt1", 6'(k), 1'b1, 1'b0, 1'b1, k == 0);
        step("auto_wrap1", 6'd62, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 61; k >= 0; k--)
            step("auto_cnt2", 6'(k), 1'b1, 1'b0, 1'b1, k == 0);
        step("auto_wrap2", 6'd62, 1'b1, 1'b1, 1'b1, 1'b0);
        step("auto_after", 6'd61, 1'b1, 1'b0, 1'b1, 1'b0);
`else
        // Full pass: Q=62 after edge 1, Q=0 after edge 63, DONE after 64.
        step("pass_start", 6'd62, 1'b1, 1'b0, 1'b1, 1'b0);
        START = 1'b0;
        for (int k = 61; k >= 0; k--)
            step("pass_cnt", 6'(k), 1'b1, 1'b0, 1'b1, k == 0);
        step("pass_done", 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("pass_after", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        ENT = 1'b0;
        step("idle_rbo_ent0", 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        ENT = 1'b1;
        step("idle_hold", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Stall at Q=40.
        START = 1'b1;
        step("stall_start", 6'd62, 1'b1, 1'b0, 1'b1, 1'b0);
        START = 1'b0;
        for (int k = 61; k >= 40; k--)
            step("stall_cnt", 6'(k), 1'b1, 1'b0, 1'b1, 1'b0);
        ENP = 1'b0;
        repeat (5) step("stall_enp0", 6'd40, 1'b1, 1'b0, 1'b1, 1'b0);
        ENP = 1'b1; ENT = 1'b0;
        repeat (2) step("stall_ent0", 6'd40, 1'b1, 1'b0, 1'b1, 1'b0);
        ENT = 1'b1;
        START = 1'b1;   // ignored while running
        for (int k = 39; k >= 30; k--)
            step("run_start_ignored", 6'(k), 1'b1, 1'b0, 1'b1, 1'b0);
        START = 1'b0;

        // Load mid-run at Q=30, then six enabled edges to DONE.
        LD = 1'b1; D = 6'd5;
        step("ld_mid", 6'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        LD = 1'b0;
        for (int k = 4; k >= 0; k--)
            step("ld_cnt", 6'(k), 1'b1, 1'b0, 1'b1, k == 0);
        step("ld_done", 6'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Load on the terminal edge suppresses DONE and stays in RUN.
        START = 1'b1;
        step("lt_start", 6'd62, 1'b1, 1'b0, 1'b1, 1'b0);
        START = 1'b0;
        for (int k = 61; k >= 0; k--)
            step("lt_cnt", 6'(k), 1'b1, 1'b0, 1'b1, k == 0);
        LD = 1'b1; D = 6'd20;
        step("ld_terminal", 6'd20, 1'b1, 1'b0, 1'b1, 1'b0);
        LD = 1'b0;
        for (int k = 19; k >= 17; k--)
            step("lt_cnt2", 6'(k), 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-run at Q=17 with START asserted.
        CLR_N = 1'b0; START = 1'b1;
        step("reset_mid", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        CLR_N = 1'b1; START = 1'b0;
        step("reset_mid_hold", 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // LD beats START in IDLE: load without entering RUN.
        START = 1'b1; LD = 1'b1; D = 6'd33;
        step("ld_idle", 6'd33, 1'b0, 1'b0, 1'b1, 1'b0);
        START = 1'b0; LD = 1'b0;
        step("ld_idle_hold", 6'd33, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expectations and %0d DONE pulses pending, expected 0 and 0",
                     exp_q.size(), done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tap_down_sequencer
`default_nettype wire
